// File: rtl/time_set_ctrl.sv
// time_set_ctrl: button-driven time editor that snapshots the live time, edits shadow copies
// and commits them to the counter chain as three single-cycle load writes (seconds first).
module time_set_ctrl #(
    parameter int HOURS_MAX      = 23,
    parameter int TIMEOUT_CYCLES = 50_000_000,
    parameter int TO_W           = 26
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_ok,
    input  logic [5:0] cur_seconds,
    input  logic [5:0] cur_minutes,
    input  logic [5:0] cur_hours,
    output logic       load,
    output logic [1:0] addrs,
    output logic [5:0] data_in,
    output logic       edit_active,
    output logic [1:0] edit_field,
    output logic [5:0] edit_value
);
    typedef enum logic [2:0] {IDLE, EDIT_HR, EDIT_MIN, EDIT_SEC, WR_SEC, WR_MIN, WR_HR} state_t;

    state_t            state, state_n;
    logic [5:0]        sh_hr, sh_min, sh_sec, sh_hr_n, sh_min_n, sh_sec_n;
    logic [TO_W-1:0]   cnt, cnt_n;
    logic              editing, editing_n, expire, load_n;
    logic [1:0]        fld, code_n;
    logic [5:0]        sel, fmax, adj;

    function automatic logic [1:0] code_of(input state_t s);
        return (s == EDIT_HR || s == WR_HR) ? 2'b10 : (s == EDIT_MIN || s == WR_MIN) ? 2'b01 : 2'b00;
    endfunction

    function automatic logic [5:0] pick(input logic [1:0] c, input logic [5:0] h, m, s);
        return c == 2'b10 ? h : c == 2'b01 ? m : s;
    endfunction

    always_comb begin
        editing  = state inside {EDIT_HR, EDIT_MIN, EDIT_SEC};
        expire   = (TIMEOUT_CYCLES != 0) && (cnt == TO_W'(TIMEOUT_CYCLES - 1));
        fld      = code_of(state);
        sel      = pick(fld, sh_hr, sh_min, sh_sec);
        fmax     = fld == 2'b10 ? 6'(HOURS_MAX) : 6'd59;
        // Out-of-range snapshots land on 0 (up) or the field max (down)
        adj      = (btn_up && !btn_down) ? (sel >= fmax ? 6'd0 : sel + 6'd1) :
                   (btn_down && !btn_up) ? ((sel == 6'd0 || sel > fmax) ? fmax : sel - 6'd1) : sel;
        state_n  = state;
        sh_hr_n  = sh_hr;
        sh_min_n = sh_min;
        sh_sec_n = sh_sec;
        cnt_n    = '0;
        unique case (state)
            IDLE: if (btn_mode) begin
                state_n  = EDIT_HR;
                sh_hr_n  = cur_hours;
                sh_min_n = cur_minutes;
                sh_sec_n = cur_seconds;
            end
            EDIT_HR, EDIT_MIN, EDIT_SEC: begin
                if (btn_ok)
                    state_n = WR_SEC;
                else if (btn_mode)
                    state_n = state == EDIT_HR ? EDIT_MIN : state == EDIT_MIN ? EDIT_SEC : EDIT_HR;
                else if (btn_up || btn_down) begin
                    sh_hr_n  = fld == 2'b10 ? adj : sh_hr;
                    sh_min_n = fld == 2'b01 ? adj : sh_min;
                    sh_sec_n = fld == 2'b00 ? adj : sh_sec;
                end else if (expire)
                    state_n = IDLE;
                else
                    cnt_n = cnt + 1'b1;
            end
            WR_SEC:  state_n = WR_MIN;
            WR_MIN:  state_n = WR_HR;
            default: state_n = IDLE;
        endcase
        editing_n = state_n inside {EDIT_HR, EDIT_MIN, EDIT_SEC};
        load_n    = state_n inside {WR_SEC, WR_MIN, WR_HR};
        code_n    = code_of(state_n);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            sh_hr       <= '0;
            sh_min      <= '0;
            sh_sec      <= '0;
            cnt         <= '0;
            load        <= 1'b0;
            addrs       <= 2'b00;
            data_in     <= '0;
            edit_active <= 1'b0;
            edit_field  <= 2'b00;
            edit_value  <= '0;
        end else begin
            state       <= state_n;
            sh_hr       <= sh_hr_n;
            sh_min      <= sh_min_n;
            sh_sec      <= sh_sec_n;
            cnt         <= cnt_n;
            load        <= load_n;
            addrs       <= load_n ? code_n : 2'b00;
            data_in     <= load_n ? pick(code_n, sh_hr_n, sh_min_n, sh_sec_n) : 6'd0;
            edit_active <= editing_n;
            edit_field  <= editing_n ? code_n : 2'b00;
            edit_value  <= editing_n ? pick(code_n, sh_hr_n, sh_min_n, sh_sec_n) : 6'd0;
        end
    end
endmodule

// File: tb/tb_time_set_ctrl.sv
// tb_time_set_ctrl: directed vectors for time_set_ctrl with an 8-cycle timeout.
module tb_time_set_ctrl;
    logic       clk = 1'b0, reset = 1'b1;
    logic       btn_mode = 0, btn_up = 0, btn_down = 0, btn_ok = 0;
    logic [5:0] cur_seconds = 0, cur_minutes = 0, cur_hours = 0;
    logic       load, edit_active;
    logic [1:0] addrs, edit_field;
    logic [5:0] data_in, edit_value;
    int         n_tests = 0, n_fail = 0;

    time_set_ctrl #(.HOURS_MAX(23), .TIMEOUT_CYCLES(8), .TO_W(4)) dut (
        .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
        .btn_ok(btn_ok), .cur_seconds(cur_seconds), .cur_minutes(cur_minutes), .cur_hours(cur_hours),
        .load(load), .addrs(addrs), .data_in(data_in), .edit_active(edit_active),
        .edit_field(edit_field), .edit_value(edit_value)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic m, u, d, o);
        {btn_mode, btn_up, btn_down, btn_ok} = {m, u, d, o};
        tick();
        {btn_mode, btn_up, btn_down, btn_ok} = 4'b0000;
    endtask

    task automatic set_cur(input int h, m, s);
        cur_hours = 6'(h);
        cur_minutes = 6'(m);
        cur_seconds = 6'(s);
    endtask

    task automatic edit_chk(input string tag, input int f, input int v);
        check({tag, ".active"}, int'(edit_active), 1);
        check({tag, ".field"}, int'(edit_field), f);
        check({tag, ".value"}, int'(edit_value), v);
    endtask

    // Call right after the cycle in which btn_ok was sampled
    task automatic commit_chk(input string tag, input int s, input int m, input int h);
        check({tag, ".ld0"}, int'(load), 1);
        check({tag, ".a0"}, int'(addrs), 0);
        check({tag, ".d0"}, int'(data_in), s);
        check({tag, ".act0"}, int'(edit_active), 0);
        tick();
        check({tag, ".ld1"}, int'(load), 1);
        check({tag, ".a1"}, int'(addrs), 1);
        check({tag, ".d1"}, int'(data_in), m);
        tick();
        check({tag, ".ld2"}, int'(load), 1);
        check({tag, ".a2"}, int'(addrs), 2);
        check({tag, ".d2"}, int'(data_in), h);
        tick();
        check({tag, ".ld3"}, int'(load), 0);
        check({tag, ".a3"}, int'(addrs), 0);
        check({tag, ".d3"}, int'(data_in), 0);
        check({tag, ".act3"}, int'(edit_active), 0);
    endtask

    initial begin
        int seen_load;
        tick();
        tick();
        reset = 1'b0;
        check("rst.load", int'(load), 0);
        check("rst.addrs", int'(addrs), 0);
        check("rst.data", int'(data_in), 0);
        check("rst.active", int'(edit_active), 0);
        check("rst.field", int'(edit_field), 0);
        check("rst.value", int'(edit_value), 0);

        set_cur(12, 34, 56);
        press(1, 0, 0, 0);
        edit_chk("snap", 2, 12);
        set_cur(1, 1, 1);
        press(0, 0, 0, 1);
        commit_chk("commit", 56, 34, 12);

        set_cur(23, 59, 0);
        press(1, 0, 0, 0);
        edit_chk("wrap.hr", 2, 23);
        press(0, 1, 0, 0);
        edit_chk("wrap.hr_up", 2, 0);
        press(1, 0, 0, 0);
        edit_chk("wrap.min", 1, 59);
        press(0, 1, 0, 0);
        edit_chk("wrap.min_up", 1, 0);
        press(1, 0, 0, 0);
        edit_chk("wrap.sec", 0, 0);
        press(0, 0, 1, 0);
        edit_chk("wrap.sec_dn", 0, 59);
        press(1, 0, 0, 0);
        edit_chk("wrap.cycle_hr", 2, 0);
        press(0, 0, 0, 1);
        commit_chk("wrap", 59, 0, 0);

        set_cur(5, 7, 9);
        press(1, 0, 0, 0);
        press(1, 0, 0, 0);
        edit_chk("prio.min", 1, 7);
        press(0, 1, 1, 0);
        edit_chk("prio.updn", 1, 7);
        press(1, 0, 0, 1);
        commit_chk("prio.okmode", 9, 7, 5);

        set_cur(0, 0, 0);
        press(1, 0, 0, 0);
        press(0, 0, 1, 0);
        edit_chk("hr.dn_wrap", 2, 23);
        press(0, 1, 0, 0);
        edit_chk("hr.up_wrap", 2, 0);
        press(0, 0, 0, 1);
        commit_chk("hr", 0, 0, 0);

        set_cur(30, 61, 63);
        press(1, 0, 0, 0);
        edit_chk("oor.snap", 2, 30);
        press(0, 1, 0, 0);
        edit_chk("oor.hr_up", 2, 0);
        press(1, 0, 0, 0);
        press(0, 0, 1, 0);
        edit_chk("oor.min_dn", 1, 59);
        press(0, 0, 0, 1);
        commit_chk("oor", 63, 59, 0);

        press(1, 0, 0, 0);
        seen_load = 0;
        for (int i = 0; i < 7; i++) begin
            tick();
            seen_load |= int'(load);
        end
        check("to.still_active", int'(edit_active), 1);
        tick();
        seen_load |= int'(load);
        check("to.dropped", int'(edit_active), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            seen_load |= int'(load);
        end
        check("to.no_load", seen_load, 0);

        set_cur(8, 9, 10);
        press(1, 0, 0, 0);
        for (int i = 0; i < 7; i++) tick();
        check("to_ok.active", int'(edit_active), 1);
        press(0, 0, 0, 1);
        commit_chk("to_ok", 10, 9, 8);

        set_cur(1, 2, 3);
        press(1, 0, 0, 0);
        press(0, 0, 0, 1);
        tick();
        check("rstmid.wrmin_ld", int'(load), 1);
        check("rstmid.wrmin_a", int'(addrs), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rstmid.load", int'(load), 0);
        check("rstmid.addrs", int'(addrs), 0);
        check("rstmid.data", int'(data_in), 0);
        check("rstmid.active", int'(edit_active), 0);
        check("rstmid.field", int'(edit_field), 0);
        check("rstmid.value", int'(edit_value), 0);
        tick();
        check("rstmid.no_hr", int'(load), 0);

        press(0, 1, 0, 0);
        check("idle.up_ld", int'(load), 0);
        check("idle.up_act", int'(edit_active), 0);
        press(0, 0, 1, 0);
        check("idle.dn_act", int'(edit_active), 0);
        press(0, 0, 0, 1);
        check("idle.ok_ld", int'(load), 0);
        check("idle.ok_act", int'(edit_active), 0);
        tick();
        check("idle.ok_ld2", int'(load), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
